// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator control path.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        LATCH,
        TRANSFER,
        RELEASE
    } ctrl_state_t;

    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

endpackage

// File: rtl/calc_ctrl_fsm_bit_counter.sv
// Bit index counter for the serial result transfer; tc flags the last bit.
module ctrl_bit_counter
    import calc_pkg::*;
#(
    parameter  int unsigned SER_BITS = 8,
    localparam int unsigned CNT_W    = $clog2(SER_BITS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == CNT_W'(SER_BITS - 1));

endmodule

// File: rtl/calc_ctrl_fsm.sv
// Main sequencing FSM for the calculator: memory write, or read/latch/serial transfer.
module calc_ctrl_fsm
    import calc_pkg::*;
#(
    parameter  int unsigned SER_BITS = 8,
    localparam int unsigned CNT_W    = $clog2(SER_BITS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic             mode,
    input  logic             valid_cmd,
    output logic             busy,
    output logic             access_mem,
    output logic             rw_mem,
    output logic             sample_data,
    output logic             transfer_data,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             done
);

    ctrl_state_t state_q, state_d;

    logic busy_q, busy_d;
    logic access_mem_q, access_mem_d;
    logic rw_mem_q, rw_mem_d;
    logic sample_data_q, sample_data_d;
    logic transfer_data_q, transfer_data_d;
    logic done_q, done_d;

    logic cnt_clear;
    logic cnt_enable;
    logic cnt_tc;

    // Counter holds 0 outside TRANSFER and wraps back to 0 on the last bit.
    assign cnt_clear  = (state_d != TRANSFER);
    assign cnt_enable = (state_q == TRANSFER);

    ctrl_bit_counter #(
        .SER_BITS (SER_BITS)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (bit_cnt),
        .tc     (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_cmd && active) begin
                    state_d = (mode == MODE_READ) ? READ : WRITE;
                end
            end
            WRITE:    state_d = RELEASE;
            READ:     state_d = LATCH;
            LATCH:    state_d = TRANSFER;
            TRANSFER: begin
                if (cnt_tc) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!valid_cmd) begin
                    state_d = IDLE;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        busy_d          = (state_d != IDLE);
        access_mem_d    = 1'b0;
        rw_mem_d        = 1'b0;
        sample_data_d   = 1'b0;
        transfer_data_d = 1'b0;
        done_d          = 1'b0;
        case (state_d)
            WRITE: begin
                access_mem_d  = 1'b1;
                rw_mem_d      = 1'b1;
                sample_data_d = 1'b1;
            end
            READ:     access_mem_d    = 1'b1;
            LATCH:    sample_data_d   = 1'b1;
            TRANSFER: transfer_data_d = 1'b1;
            RELEASE:  done_d          = (state_q != RELEASE);
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            access_mem_q    <= 1'b0;
            rw_mem_q        <= 1'b0;
            sample_data_q   <= 1'b0;
            transfer_data_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            access_mem_q    <= access_mem_d;
            rw_mem_q        <= rw_mem_d;
            sample_data_q   <= sample_data_d;
            transfer_data_q <= transfer_data_d;
            done_q          <= done_d;
        end
    end

    assign busy          = busy_q;
    assign access_mem    = access_mem_q;
    assign rw_mem        = rw_mem_q;
    assign sample_data   = sample_data_q;
    assign transfer_data = transfer_data_q;
    assign done          = done_q;

endmodule

// File: tb/tb_calc_ctrl_fsm.sv
// Scoreboard bench for calc_ctrl_fsm: expected output events are queued per command, a monitor checks them.
module tb_calc_ctrl_fsm;
    import calc_pkg::*;

    localparam int unsigned SER_BITS = 8;
    localparam int unsigned CNT_W    = $clog2(SER_BITS);

    logic             clk = 1'b0;
    logic             reset;
    logic             active;
    logic             mode;
    logic             valid_cmd;
    logic             busy;
    logic             access_mem;
    logic             rw_mem;
    logic             sample_data;
    logic             transfer_data;
    logic [CNT_W-1:0] bit_cnt;
    logic             done;

    typedef struct {
        int unsigned      cyc;
        logic [4:0]       outs;   // {access_mem, rw_mem, sample_data, transfer_data, done}
        logic [CNT_W-1:0] bc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc      = 0;
    int          checks   = 0;
    int          failures = 0;

    calc_ctrl_fsm #(
        .SER_BITS (SER_BITS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .active        (active),
        .mode          (mode),
        .valid_cmd     (valid_cmd),
        .busy          (busy),
        .access_mem    (access_mem),
        .rw_mem        (rw_mem),
        .sample_data   (sample_data),
        .transfer_data (transfer_data),
        .bit_cnt       (bit_cnt),
        .done          (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push(input int unsigned c, input logic [4:0] o, input logic [CNT_W-1:0] b);
        exp_t e;
        e.cyc  = c;
        e.outs = o;
        e.bc   = b;
        sb.push_back(e);
    endfunction

    // Hand-written event sequences; e is the cycle right after the sampling edge.
    function automatic void expect_op(input logic m, input int unsigned e, input int unsigned nbits,
                                      input bit with_done);
        if (m == MODE_WRITE) begin
            push(e, 5'b11100, '0);
            if (with_done) push(e + 1, 5'b00001, '0);
        end else begin
            push(e,     5'b10000, '0);
            push(e + 1, 5'b00100, '0);
            for (int unsigned i = 0; i < nbits; i++) push(e + 2 + i, 5'b00010, CNT_W'(i));
            if (with_done) push(e + 2 + SER_BITS, 5'b00001, '0);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a command for exactly one sampling edge; returns just after that edge.
    task automatic issue(input logic m, input int unsigned nbits, input bit with_done);
        valid_cmd = 1'b1;
        active    = 1'b1;
        mode      = m;
        expect_op(m, cyc + 1, nbits, with_done);
        tick(1);
    endtask

    always @(negedge clk) begin
        if (access_mem || sample_data || transfer_data || done) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {27'd0, access_mem, rw_mem, sample_data, transfer_data, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("event_outputs", {27'd0, access_mem, rw_mem, sample_data, transfer_data, done},
                    {27'd0, e.outs});
                chk("event_bit_cnt", 32'(bit_cnt), 32'(e.bc));
                chk("event_busy", {31'd0, busy}, 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with a command pending: reset wins.
        reset     = 1'b1;
        valid_cmd = 1'b1;
        active    = 1'b1;
        mode      = MODE_WRITE;
        tick(2);
        chk("reset_outputs", {25'd0, busy, access_mem, rw_mem, sample_data, transfer_data, done, 32'(bit_cnt)} , 32'd0);

        // Releasing reset: the still-present write command is taken on the next edge.
        reset = 1'b0;
        expect_op(MODE_WRITE, cyc + 1, 0, 1'b1);
        tick(1);
        chk("write_busy", {31'd0, busy}, 32'd1);
        tick(4);
        chk("write_release_hold", {31'd0, busy}, 32'd1);
        valid_cmd = 1'b0;
        tick(1);
        chk("write_idle", {31'd0, busy}, 32'd0);

        // Full read/transfer; valid_cmd dropped mid-operation is ignored.
        issue(MODE_READ, SER_BITS, 1'b1);
        valid_cmd = 1'b0;
        tick(10);
        chk("read_release_busy", {31'd0, busy}, 32'd1);
        tick(1);
        chk("read_idle", {31'd0, busy}, 32'd0);

        // Bad key: command held, nothing must start.
        active    = 1'b0;
        valid_cmd = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("gated_busy", {31'd0, busy}, 32'd0);
        end
        valid_cmd = 1'b0;
        tick(1);

        // Held command across done gives exactly one write.
        issue(MODE_WRITE, 0, 1'b1);
        tick(6);
        chk("retrigger_busy", {31'd0, busy}, 32'd1);
        chk("retrigger_single_op", sb.size(), 32'd0);
        valid_cmd = 1'b0;
        tick(1);
        chk("retrigger_idle", {31'd0, busy}, 32'd0);

        // Reset during TRANSFER right after bit 3 is shown.
        issue(MODE_READ, 4, 1'b0);
        valid_cmd = 1'b0;
        tick(5);
        reset = 1'b1;
        tick(1);
        chk("abort_outputs", {25'd0, busy, access_mem, rw_mem, sample_data, transfer_data, done, 32'(bit_cnt)}, 32'd0);
        reset = 1'b0;
        tick(2);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        issue(MODE_READ, SER_BITS, 1'b1);
        valid_cmd = 1'b0;
        tick(11);
        chk("restart_idle", {31'd0, busy}, 32'd0);

        // Mode and key toggled during TRANSFER with command held.
        issue(MODE_READ, SER_BITS, 1'b1);
        tick(3);
        mode   = MODE_WRITE;
        active = 1'b0;
        tick(2);
        mode   = MODE_READ;
        active = 1'b1;
        tick(7);
        chk("modechg_release_busy", {31'd0, busy}, 32'd1);
        valid_cmd = 1'b0;
        tick(1);
        chk("modechg_idle", {31'd0, busy}, 32'd0);

        tick(3);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
